// File: rtl/ll_ctrl_pkg.sv
// rtl/ll_ctrl_pkg.sv - shared types and constants for the line-length controller
package ll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_STALL = 2'd3
  } ll_state_t;

  localparam int DEF_WIN_LEN = 50;
  localparam int HYST_CNT    = 3;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ll_ctrl_if.sv
// rtl/ll_ctrl_if.sv - sample stream, datapath and result signals of the controller
interface ll_ctrl_if #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 25
);
  logic                           s_valid;
  logic signed [INPUT_WIDTH-1:0]  s_data;
  logic                           s_ready;
  logic signed [INPUT_WIDTH-1:0]  ll_din;
  logic                           ll_en;
  logic                           ll_rst;
  logic signed [OUTPUT_WIDTH-1:0] ll_dout;
  logic                           ll_valid;
  logic                           res_valid;
  logic                           res_ready;
  logic signed [OUTPUT_WIDTH-1:0] res_ll;
  logic                           res_det;

  // environment side: sample source, datapath, result sink
  modport master (
    output s_valid, s_data, ll_dout, ll_valid, res_ready,
    input  s_ready, ll_din, ll_en, ll_rst, res_valid, res_ll, res_det
  );

  // controller side
  modport slave (
    input  s_valid, s_data, ll_dout, ll_valid, res_ready,
    output s_ready, ll_din, ll_en, ll_rst, res_valid, res_ll, res_det
  );
endinterface

// File: rtl/ll_win_counter.sv
// rtl/ll_win_counter.sv - per-window sample counter with wrap pulse
module ll_win_counter
  import ll_ctrl_pkg::*;
#(
  parameter  int WIN_LEN = DEF_WIN_LEN,
  localparam int CW      = cnt_w(WIN_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap
);

  assign wrap = inc && (count == CW'(WIN_LEN - 1));

  // count accepted samples 0..WIN_LEN-1, back to 0 on the window-closing sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || wrap) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ll_ctrl.sv
// rtl/ll_ctrl.sv - line-length window controller; LL_CTRL_HYST_EN enables 3-result detection hysteresis
module ll_ctrl
  import ll_ctrl_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 25,
  parameter int WIN_LEN      = DEF_WIN_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic signed [OUTPUT_WIDTH-1:0] threshold,
  output logic                           busy,
  ll_ctrl_if.slave                       bus
);

  localparam int CW = cnt_w(WIN_LEN);

  ll_state_t     state, state_nx;
  logic [CW-1:0] count;
  logic          wrap;
  logic          accept;
  logic          stop_pend;
  logic          stop_req;
  logic          stop_now;
  logic          cap_pend;
  logic          capture;
  logic          above;
  logic          det_nx;

  assign stop_req = stop || stop_pend;
  // a stop with no partial window in flight ends the run without taking another sample
  assign stop_now = stop_req && (count == '0);
  // the window result is taken once the result slot is free or being drained this cycle
  assign capture  = cap_pend && (!bus.res_valid || bus.res_ready);
  assign above    = bus.ll_dout > threshold;
  assign bus.ll_din = INPUT_WIDTH'(bus.s_data);

  ll_win_counter #(.WIN_LEN(WIN_LEN)) u_win_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == ST_CLEAR),
    .inc   (accept),
    .count (count),
    .wrap  (wrap)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // next-state: a window end with an undrained result stalls the input
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_CLEAR;
      ST_CLEAR: state_nx = ST_RUN;
      ST_RUN: begin
        if (wrap) begin
          if (bus.res_valid && !bus.res_ready) state_nx = ST_STALL;
          else if (stop_req)                   state_nx = ST_IDLE;
        end else if (stop_now) begin
          state_nx = ST_IDLE;
        end
      end
      ST_STALL: if (bus.res_ready) state_nx = stop_req ? ST_IDLE : ST_RUN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // outputs: datapath is held in reset while rst is low or during CLEAR
  always_comb begin
    bus.s_ready = 1'b0;
    bus.ll_rst  = !rst;
    busy        = 1'b1;
    unique case (state)
      ST_IDLE:  busy        = 1'b0;
      ST_CLEAR: bus.ll_rst  = 1'b1;
      ST_RUN:   bus.s_ready = !stop_now;
      ST_STALL: bus.s_ready = 1'b0;
      default:  busy        = 1'b0;
    endcase
    accept     = bus.s_valid && bus.s_ready;
    bus.ll_en  = !accept;
  end

  // remember a stop request until the run returns to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stop_pend <= 1'b0;
    end else if (state_nx == ST_IDLE) begin
      stop_pend <= 1'b0;
    end else if (state != ST_IDLE && stop) begin
      stop_pend <= 1'b1;
    end
  end

  // flag that the datapath holds a completed window awaiting capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_pend <= 1'b0;
    end else if (wrap) begin
      cap_pend <= 1'b1;
    end else if (capture) begin
      cap_pend <= 1'b0;
    end
  end

`ifdef LL_CTRL_HYST_EN
  localparam int SW = $clog2(HYST_CNT + 1);
  logic [SW-1:0] streak;

  assign det_nx = above && (streak >= SW'(HYST_CNT - 1));

  // run length of consecutive above-threshold results, saturating at HYST_CNT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (state == ST_CLEAR) begin
      streak <= '0;
    end else if (capture && bus.ll_valid) begin
      if (!above)                         streak <= '0;
      else if (streak != SW'(HYST_CNT))   streak <= streak + 1'b1;
    end
  end
`else
  assign det_nx = above;
`endif

  // result holding register; a simultaneous drain and capture reloads without a gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.res_valid <= 1'b0;
      bus.res_ll    <= '0;
      bus.res_det   <= 1'b0;
    end else if (capture && bus.ll_valid) begin
      bus.res_valid <= 1'b1;
      bus.res_ll    <= bus.ll_dout;
      bus.res_det   <= det_nx;
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ll_ctrl.sv
// tb/tb_ll_ctrl.sv - directed bench for ll_ctrl with a behavioural line-length datapath
module tb_ll_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic signed [24:0] threshold;
  logic               busy;

  ll_ctrl_if #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(25)) bus ();

  ll_ctrl #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(25), .WIN_LEN(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .threshold (threshold),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural datapath: cumulative sum of |x[n]-x[n-1]| since its last reset
  int acc = 0;
  int n   = 0;
  int prv = 0;
  int valid_from = 250;

  assign bus.ll_dout  = acc[24:0];
  assign bus.ll_valid = (n > valid_from);

  always @(posedge clk) begin
    int d;
    d = int'(bus.ll_din) - prv;
    if (d < 0) d = -d;
    if (bus.ll_rst) begin
      acc <= 0;
      n   <= 0;
      prv <= 0;
    end else if (!bus.ll_en) begin
      acc <= acc + d;
      prv <= int'(bus.ll_din);
      n   <= n + 1;
    end
  end

  // record every consumed result
  int rq_ll[$];
  int rq_det[$];
  always @(posedge clk) begin
    if (rst && bus.res_valid && bus.res_ready) begin
      rq_ll.push_back(int'(bus.res_ll));
      rq_det.push_back(int'(bus.res_det));
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int sidx = 0;

  task automatic run_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sidx  = 0;
  endtask

  task automatic stop_pulse();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic send(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = (sidx % 2 == 0) ? 16'sd1000 : -16'sd1000;
      while (!bus.s_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        chk("send_timeout", guard, 0);
        bus.s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      sidx++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  function automatic int q_ll(input int i);
    return (i < rq_ll.size()) ? rq_ll[i] : -1;
  endfunction

  function automatic int q_det(input int i);
    return (i < rq_det.size()) ? rq_det[i] : -1;
  endfunction

  initial begin
    int base;
    int taken;
    rst = 1'b0; start = 1'b0; stop = 1'b0; threshold = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.res_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_s_ready",   bus.s_ready,   0);
    chk("rst_ll_en",     bus.ll_en,     1);
    chk("rst_ll_rst",    bus.ll_rst,    1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_busy",      busy,          0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ll_rst",   bus.ll_rst,    0);

    // scenario 1: only the window ending at sample 300 is valid, threshold 0
    base = rq_ll.size();
    run_start();
    chk("clear_ll_rst", bus.ll_rst, 1);
    chk("clear_busy",   busy,       1);
    send(300);
    repeat (3) @(negedge clk);
    chk("s1_count", rq_ll.size() - base, 1);
    chk("s1_ll",    q_ll(base),  599000);
    chk("s1_det",   q_det(base), 1);
    stop_pulse();
    chk("s1_idle_busy", busy, 0);

    // scenario 2: same stream, maximum positive threshold
    threshold = 25'sd16777215;
    base = rq_ll.size();
    run_start();
    send(300);
    repeat (3) @(negedge clk);
    chk("s2_count", rq_ll.size() - base, 1);
    chk("s2_ll",    q_ll(base),  599000);
    chk("s2_det",   q_det(base), 0);
    stop_pulse();
    threshold = '0;

    // scenario 3: result not drained across two window ends
    valid_from    = 0;
    bus.res_ready = 1'b0;
    base = rq_ll.size();
    run_start();
    send(100);
    chk("s3_stall_s_ready", bus.s_ready,   0);
    chk("s3_stall_busy",    busy,          1);
    chk("s3_stall_valid",   bus.res_valid, 1);
    chk("s3_stall_ll",      bus.res_ll,    99000);
    repeat (3) @(negedge clk);
    chk("s3_stall_hold_ll", bus.res_ll,    99000);
    chk("s3_stall_hold_rdy", bus.s_ready,  0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("s3_reload_ll",    bus.res_ll,    199000);
    chk("s3_reload_valid", bus.res_valid, 1);
    chk("s3_run_s_ready",  bus.s_ready,   1);
    repeat (2) @(negedge clk);
    chk("s3_count", rq_ll.size() - base, 2);
    chk("s3_first", q_ll(base),     99000);
    chk("s3_second", q_ll(base + 1), 199000);
    stop_pulse();

    // scenario 4: stop at sample 20 lets the window finish
    base = rq_ll.size();
    run_start();
    send(20);
    stop_pulse();
    taken = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = (sidx % 2 == 0) ? 16'sd1000 : -16'sd1000;
      if (bus.s_ready) begin
        taken++;
        sidx++;
      end
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("s4_taken",   taken,       30);
    chk("s4_busy",    busy,        0);
    chk("s4_s_ready", bus.s_ready, 0);
    chk("s4_ll",      q_ll(base),  99000);

    // scenario 5: asynchronous reset mid-window, then a clean rerun
    run_start();
    send(17);
    rst = 1'b0;
    #1;
    chk("s5_s_ready",  bus.s_ready,   0);
    chk("s5_ll_en",    bus.ll_en,     1);
    chk("s5_ll_rst",   bus.ll_rst,    1);
    chk("s5_busy",     busy,          0);
    chk("s5_res_valid", bus.res_valid, 0);
    chk("s5_res_ll",   bus.res_ll,    0);
    chk("s5_res_det",  bus.res_det,   0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    threshold = 25'sd99000;
    base = rq_ll.size();
    run_start();
    send(50);
    repeat (3) @(negedge clk);
    chk("s5_rerun_count", rq_ll.size() - base, 1);
    chk("s5_rerun_ll",    q_ll(base),  99000);
    chk("s5_equal_det",   q_det(base), 0);
    stop_pulse();

    // scenario 6: above, above, above, below
    threshold = '0;
    base = rq_ll.size();
    run_start();
    send(150);
    repeat (2) @(negedge clk);
    threshold = 25'sd16777215;
    send(50);
    repeat (3) @(negedge clk);
    stop_pulse();
    chk("s6_count", rq_ll.size() - base, 4);
    chk("s6_ll3",   q_ll(base + 3), 399000);
`ifdef LL_CTRL_HYST_EN
    chk("s6_det0", q_det(base),     0);
    chk("s6_det1", q_det(base + 1), 0);
    chk("s6_det2", q_det(base + 2), 1);
    chk("s6_det3", q_det(base + 3), 0);
`else
    chk("s6_det0", q_det(base),     1);
    chk("s6_det1", q_det(base + 1), 1);
    chk("s6_det2", q_det(base + 2), 1);
    chk("s6_det3", q_det(base + 3), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ll_ctrl.md
LL_CTRL -- requirements
Module: ll_ctrl

Interface
REQ-001 The interface SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be: INPUT_WIDTH, default 16, sample width; OUTPUT_WIDTH, default 25, line-length value width; WIN_LEN, default 50, samples per window.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin a run.
- stop  in  1  one-cycle pulse; end the run at the next window boundary.
- threshold  in  OUTPUT_WIDTH  signed detection threshold.
- s_valid  in  1  input sample valid.
- s_data  in  INPUT_WIDTH  signed input sample.
- s_ready  out  1  controller accepts a sample.
- ll_din  out  INPUT_WIDTH  sample to the line-length datapath.
- ll_en  out  1  datapath enable, active low.
- ll_rst  out  1  datapath reset, active high.
- ll_dout  in  OUTPUT_WIDTH  datapath line-length value.
- ll_valid  in  1  datapath output is meaningful.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_ll  out  OUTPUT_WIDTH  captured line-length value.
- res_det  out  1  detection flag.
- busy  out  1  high in any state except IDLE.

Function
REQ-004 The FSM SHALL have four states: IDLE, CLEAR, RUN and STALL.
REQ-005 IDLE SHALL hold s_ready=0 and ll_en=1. On start, the FSM SHALL go to CLEAR.
REQ-006 CLEAR SHALL last exactly one cycle with ll_rst=1, SHALL clear the sample and window counters, and SHALL then go to RUN.
REQ-007 In RUN, s_ready SHALL equal 1. A sample SHALL be accepted when s_valid && s_ready.
REQ-008 On an accepted sample, ll_din SHALL equal s_data and ll_en SHALL equal 0 combinationally in the same cycle. In all other cycles ll_en SHALL equal 1, so the datapath advances exactly once per accepted sample.
REQ-009 The sample counter SHALL count 0..WIN_LEN-1 and wrap to 0 on the accepted sample that completes a window.
REQ-010 On the cycle after a window completes, if ll_valid=1, the controller SHALL capture res_ll=ll_dout, set res_det=(ll_dout > threshold) as a signed compare, and assert res_valid.
REQ-011 If ll_valid=0 at that capture cycle (warm-up), the controller SHALL produce no result and SHALL continue.
REQ-012 res_valid SHALL stay high until a cycle with res_ready=1, after which it SHALL clear. res_ll and res_det SHALL be stable while res_valid=1.
REQ-013 If a window completes while res_valid=1 and res_ready=0, the FSM SHALL enter STALL with s_ready=0. It SHALL return to RUN on the cycle res_ready=1, and the new result SHALL be captured then. No result SHALL be dropped.
REQ-014 The controller SHALL latch stop as pending. At the next capture cycle, or immediately if the sample counter is 0, the FSM SHALL go to IDLE. A pending result SHALL be retained until consumed.
REQ-015 start SHALL be ignored outside IDLE. start and stop in the same IDLE cycle SHALL be treated as start only.
REQ-016 Simultaneous capture and res_ready in the same cycle SHALL consume the old result and load the new one, with no bubble.

Reset
REQ-017 While rst=0, the following SHALL hold: state IDLE; counters 0; s_ready=0, ll_en=1, ll_rst=1, res_valid=0, res_ll=0, res_det=0, busy=0; stop pending cleared.
REQ-018 Reset asserted mid-run SHALL abort immediately, with no partial result delivered.

Configuration
REQ-019 With LL_CTRL_HYST_EN defined, res_det SHALL assert only after 3 consecutive captured results exceed threshold, and SHALL clear on the first result that does not. The streak counter SHALL reset in CLEAR and on reset.
REQ-020 Without LL_CTRL_HYST_EN, res_det SHALL be the per-window compare of REQ-010, and no streak logic SHALL be present.

Structure
REQ-021 A shared package SHALL hold the FSM state enumeration, the default WIN_LEN, and the hysteresis count 3.
REQ-022 The sample counter SHALL be one sub-module, ll_win_counter, with outputs count and wrap pulse. All other logic SHALL be flat.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Scenario 1: start, then 300 back-to-back samples of +1000/-1000 alternating, ll_valid high from sample 250, threshold 0 -> exactly 1 result, at the window ending at sample 300, with res_det=1.
- Scenario 2: same stream with threshold 2^24-1 -> res_det=0.
- Scenario 3: res_ready held 0 across 2 window ends -> STALL entered, s_ready=0, first res_ll unchanged. Release res_ready -> second result follows with no loss.
- Scenario 4: stop pulsed at sample 20 of a window -> 30 more samples accepted, then IDLE, busy=0, s_ready=0.
- Scenario 5: rst low at sample 17 -> all outputs take reset values within the same cycle, and a later start runs cleanly from CLEAR.
- Scenario 6 (LL_CTRL_HYST_EN): results above, above, above, below -> res_det sequence 0,0,1,0.
